// File: rtl/hashing_nonce_dispatch.sv
// hashing_nonce_dispatch
//   Hands one block-header job to LANES external nonce-search lanes, each
//   owning an equal, fixed slice of the nonce space. It picks the
//   lowest-indexed lane that reports a hit and presents that lane's result
//   on a valid/ready port. If every lane runs out of nonces without a hit,
//   it reports an exhausted result instead. A new job accepted while the
//   lanes are searching aborts the search and restarts all lanes.
//
// Ports
//   clk, rst            clock; synchronous active-low reset
//   job_valid/ready     job handshake; job_data is the payload
//   lane_enable         lanes may iterate (RUN only)
//   lane_restart        one-cycle pulse: lanes reload base nonce and data
//   lane_data           latched job payload for the lanes
//   lane_base           per-lane starting nonce, slice i = i*2^NONCE_W/LANES
//   lane_found          per-lane hit flags, held until restart
//   lane_nonce          per-lane golden nonces
//   lane_hash           per-lane hashes
//   lane_exhausted      per-lane slice-finished flags, held until restart
//   res_valid/ready     result handshake
//   res_nonce/hash/lane winning nonce, hash and lane index
//   res_exhausted       result means "no nonce found"
//   busy                a job is in progress or a result is pending
//   hit_count           saturating count of reported hits since reset
module hashing_nonce_dispatch #(
  parameter int LANES   = 8,
  parameter int NONCE_W = 32,
  parameter int HASH_W  = 256,
  parameter int DATA_W  = 8,
  parameter int LANE_W  = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       job_valid,
  input  logic [DATA_W-1:0]          job_data,
  output logic                       job_ready,
  output logic                       lane_enable,
  output logic                       lane_restart,
  output logic [DATA_W-1:0]          lane_data,
  output logic [LANES*NONCE_W-1:0]   lane_base,
  input  logic [LANES-1:0]           lane_found,
  input  logic [LANES*NONCE_W-1:0]   lane_nonce,
  input  logic [LANES*HASH_W-1:0]    lane_hash,
  input  logic [LANES-1:0]           lane_exhausted,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [NONCE_W-1:0]         res_nonce,
  output logic [HASH_W-1:0]          res_hash,
  output logic [LANE_W-1:0]          res_lane,
  output logic                       res_exhausted,
  output logic                       busy,
  output logic [15:0]                hit_count
);

  typedef enum logic [1:0] {IDLE, START, RUN, REPORT} state_t;

  state_t state;

  // Slice arithmetic is done one bit wider than the nonce so that 2^NONCE_W
  // itself is representable (needed when LANES == 1).
  localparam logic [NONCE_W:0] SPAN  = {1'b1, {NONCE_W{1'b0}}};
  localparam logic [NONCE_W:0] RANGE = SPAN / (NONCE_W+1)'(LANES);

  for (genvar i = 0; i < LANES; i++) begin : g_base
    localparam logic [NONCE_W:0] BASE = RANGE * (NONCE_W+1)'(i);
    assign lane_base[i*NONCE_W +: NONCE_W] = BASE[NONCE_W-1:0];
  end

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic                win_vld;
  logic [LANE_W-1:0]   win_idx;
  logic [NONCE_W-1:0]  win_nonce;
  logic [HASH_W-1:0]   win_hash;
  logic                all_exh;

  // Fixed priority: scan from the top so the lowest-indexed hit is the
  // last assignment and therefore wins.
  always_comb begin
    win_idx   = '0;
    win_nonce = '0;
    win_hash  = '0;
    for (int i = LANES-1; i >= 0; i--) begin
      if (lane_found[i]) begin
        win_idx   = LANE_W'(i);
        win_nonce = lane_nonce[i*NONCE_W +: NONCE_W];
        win_hash  = lane_hash[i*HASH_W +: HASH_W];
      end
    end
  end

  assign win_vld = |lane_found;
  assign all_exh = &lane_exhausted;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      job_ready     <= 1'b1;
      lane_enable   <= 1'b0;
      lane_restart  <= 1'b0;
      lane_data     <= '0;
      res_valid     <= 1'b0;
      res_nonce     <= '0;
      res_hash      <= '0;
      res_lane      <= '0;
      res_exhausted <= 1'b0;
      busy          <= 1'b0;
      hit_count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (job_valid) begin
            lane_data    <= job_data;
            lane_restart <= 1'b1;
            job_ready    <= 1'b0;
            busy         <= 1'b1;
            state        <= START;
          end
        end
        START: begin
          lane_restart <= 1'b0;
          lane_enable  <= 1'b1;
          job_ready    <= 1'b1;
          state        <= RUN;
        end
        RUN: begin
          // A new job outranks any hit seen in the same cycle; that hit
          // belongs to the abandoned job and is dropped.
          if (job_valid) begin
            lane_data    <= job_data;
            lane_restart <= 1'b1;
            lane_enable  <= 1'b0;
            job_ready    <= 1'b0;
            state        <= START;
          end else if (win_vld) begin
            res_valid     <= 1'b1;
            res_nonce     <= win_nonce;
            res_hash      <= win_hash;
            res_lane      <= win_idx;
            res_exhausted <= 1'b0;
            hit_count     <= sat_inc(hit_count);
            lane_enable   <= 1'b0;
            job_ready     <= 1'b0;
            state         <= REPORT;
          end else if (all_exh) begin
            res_valid     <= 1'b1;
            res_nonce     <= '0;
            res_hash      <= '0;
            res_lane      <= '0;
            res_exhausted <= 1'b1;
            lane_enable   <= 1'b0;
            job_ready     <= 1'b0;
            state         <= REPORT;
          end
        end
        REPORT: begin
          // Lanes stay frozen here, so a held hit cannot be reported twice.
          if (res_ready) begin
            res_valid <= 1'b0;
            job_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hashing_nonce_dispatch.sv
module tb_hashing_nonce_dispatch;

  localparam int L  = 8;
  localparam int NW = 32;
  localparam int HW = 256;
  localparam int DW = 8;
  localparam int LW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic               job_valid;
  logic [DW-1:0]      job_data;
  logic               job_ready;
  logic               lane_enable;
  logic               lane_restart;
  logic [DW-1:0]      lane_data;
  logic [L*NW-1:0]    lane_base;
  logic [L-1:0]       lane_found;
  logic [L*NW-1:0]    lane_nonce;
  logic [L*HW-1:0]    lane_hash;
  logic [L-1:0]       lane_exhausted;
  logic               res_valid;
  logic               res_ready;
  logic [NW-1:0]      res_nonce;
  logic [HW-1:0]      res_hash;
  logic [LW-1:0]      res_lane;
  logic               res_exhausted;
  logic               busy;
  logic [15:0]        hit_count;

  hashing_nonce_dispatch #(.LANES(L), .NONCE_W(NW), .HASH_W(HW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .job_valid(job_valid), .job_data(job_data),
    .job_ready(job_ready), .lane_enable(lane_enable), .lane_restart(lane_restart),
    .lane_data(lane_data), .lane_base(lane_base), .lane_found(lane_found),
    .lane_nonce(lane_nonce), .lane_hash(lane_hash), .lane_exhausted(lane_exhausted),
    .res_valid(res_valid), .res_ready(res_ready), .res_nonce(res_nonce),
    .res_hash(res_hash), .res_lane(res_lane), .res_exhausted(res_exhausted),
    .busy(busy), .hit_count(hit_count)
  );

  // Small build: 4 lanes, 16-bit nonces.
  logic               s_job_valid;
  logic [7:0]         s_job_data;
  logic               s_job_ready;
  logic               s_lane_enable;
  logic               s_lane_restart;
  logic [7:0]         s_lane_data;
  logic [4*16-1:0]    s_lane_base;
  logic [3:0]         s_lane_found;
  logic [4*16-1:0]    s_lane_nonce;
  logic [4*16-1:0]    s_lane_hash;
  logic [3:0]         s_lane_exhausted;
  logic               s_res_valid;
  logic               s_res_ready;
  logic [15:0]        s_res_nonce;
  logic [15:0]        s_res_hash;
  logic [1:0]         s_res_lane;
  logic               s_res_exhausted;
  logic               s_busy;
  logic [15:0]        s_hit_count;

  hashing_nonce_dispatch #(.LANES(4), .NONCE_W(16), .HASH_W(16), .DATA_W(8)) dut_small (
    .clk(clk), .rst(rst), .job_valid(s_job_valid), .job_data(s_job_data),
    .job_ready(s_job_ready), .lane_enable(s_lane_enable), .lane_restart(s_lane_restart),
    .lane_data(s_lane_data), .lane_base(s_lane_base), .lane_found(s_lane_found),
    .lane_nonce(s_lane_nonce), .lane_hash(s_lane_hash), .lane_exhausted(s_lane_exhausted),
    .res_valid(s_res_valid), .res_ready(s_res_ready), .res_nonce(s_res_nonce),
    .res_hash(s_res_hash), .res_lane(s_res_lane), .res_exhausted(s_res_exhausted),
    .busy(s_busy), .hit_count(s_hit_count)
  );

  int tests = 0;
  int fails = 0;
  logic [15:0] exp_hits;
  logic [NW-1:0] nonce_m [L];
  logic [HW-1:0] hash_m [L];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: lowest set bit index, from isolating it arithmetically.
  function automatic int lowest(input logic [L-1:0] f);
    logic [L-1:0] iso;
    iso = f & (~f + 8'd1);
    return $clog2(iso);
  endfunction

  task automatic pack();
    for (int i = 0; i < L; i++) begin
      lane_nonce[i*NW +: NW] = nonce_m[i];
      lane_hash[i*HW +: HW]  = hash_m[i];
    end
  endtask

  task automatic load_lanes();
    for (int i = 0; i < L; i++) begin
      nonce_m[i] = $urandom;
      for (int w = 0; w < HW/32; w++) hash_m[i][w*32 +: 32] = $urandom;
    end
    pack();
  endtask

  task automatic start_job(input logic [DW-1:0] d);
    job_valid = 1'b1;
    job_data  = d;
    tick();
    job_valid = 1'b0;
    job_data  = 8'($urandom);
    chk("restart_pulse", 256'(lane_restart), 256'(1'b1));
    chk("enable_in_start", 256'(lane_enable), 256'(1'b0));
    chk("lane_data", 256'(lane_data), 256'(d));
    chk("busy_start", 256'(busy), 256'(1'b1));
    tick();
    chk("restart_end", 256'(lane_restart), 256'(1'b0));
    chk("enable_run", 256'(lane_enable), 256'(1'b1));
    chk("ready_run", 256'(job_ready), 256'(1'b1));
  endtask

  task automatic run_idle(input int n);
    logic [L-1:0] e;
    for (int k = 0; k < n; k++) begin
      e = 8'($urandom);
      if (&e) e[0] = 1'b0;
      lane_found     = '0;
      lane_exhausted = e;
      tick();
      chk("no_result", 256'(res_valid), 256'(1'b0));
      chk("enable_hold", 256'(lane_enable), 256'(1'b1));
    end
  endtask

  task automatic do_result(input logic [L-1:0] f, input logic [L-1:0] e, input int hold);
    logic [NW-1:0] en;
    logic [HW-1:0] eh;
    logic [LW-1:0] el;
    logic          ex;
    int            w;
    lane_found     = f;
    lane_exhausted = e;
    tick();
    if (f != '0) begin
      w  = lowest(f);
      en = nonce_m[w];
      eh = hash_m[w];
      el = LW'(w);
      ex = 1'b0;
      if (exp_hits != 16'hFFFF) exp_hits++;
    end else begin
      en = '0;
      eh = '0;
      el = '0;
      ex = 1'b1;
    end
    chk("res_valid", 256'(res_valid), 256'(1'b1));
    chk("res_exhausted", 256'(res_exhausted), 256'(ex));
    chk("res_nonce", 256'(res_nonce), 256'(en));
    chk("res_hash", res_hash, eh);
    chk("res_lane", 256'(res_lane), 256'(el));
    chk("hit_count", 256'(hit_count), 256'(exp_hits));
    chk("enable_report", 256'(lane_enable), 256'(1'b0));
    chk("ready_report", 256'(job_ready), 256'(1'b0));
    res_ready = 1'b0;
    for (int k = 0; k < hold; k++) begin
      tick();
      chk("hold_valid", 256'(res_valid), 256'(1'b1));
      chk("hold_nonce", 256'(res_nonce), 256'(en));
      chk("hold_lane", 256'(res_lane), 256'(el));
    end
    res_ready = 1'b1;
    tick();
    res_ready      = 1'b0;
    lane_found     = '0;
    lane_exhausted = '0;
    chk("valid_drop", 256'(res_valid), 256'(1'b0));
    chk("busy_idle", 256'(busy), 256'(1'b0));
    chk("ready_idle", 256'(job_ready), 256'(1'b1));
  endtask

  initial begin
    logic [L-1:0] f;
    logic [L-1:0] e;
    int           mode;

    rst = 1'b0; job_valid = 1'b0; job_data = '0; res_ready = 1'b0;
    lane_found = '0; lane_exhausted = '0; lane_nonce = '0; lane_hash = '0;
    s_job_valid = 1'b0; s_job_data = '0; s_res_ready = 1'b0;
    s_lane_found = '0; s_lane_exhausted = '0; s_lane_nonce = '0; s_lane_hash = '0;
    exp_hits = '0;
    tick();
    tick();
    rst = 1'b1;

    // Reset state
    chk("rst_job_ready", 256'(job_ready), 256'(1'b1));
    chk("rst_res_valid", 256'(res_valid), 256'(1'b0));
    chk("rst_enable", 256'(lane_enable), 256'(1'b0));
    chk("rst_restart", 256'(lane_restart), 256'(1'b0));
    chk("rst_lane_data", 256'(lane_data), 256'(0));
    chk("rst_hit_count", 256'(hit_count), 256'(0));
    chk("rst_busy", 256'(busy), 256'(1'b0));

    // Test 1: lane 3 hit on a fixed nonce
    load_lanes();
    nonce_m[3] = 32'h6000_0010;
    pack();
    start_job(8'hA5);
    run_idle(8);
    do_result(8'h08, 8'h00, 2);
    chk("t1_hits", 256'(hit_count), 256'(16'd1));

    // Test 2: two lanes at once, long hold
    load_lanes();
    start_job(8'($urandom));
    run_idle(3);
    do_result(8'h24, 8'h00, 20);

    // Test 3: full exhaustion, then exhaustion plus a hit on lane 7
    load_lanes();
    start_job(8'($urandom));
    do_result(8'h00, 8'hFF, 3);
    load_lanes();
    start_job(8'($urandom));
    run_idle(2);
    do_result(8'h80, 8'hFF, 1);

    // Test 4: new job aborts a same-cycle hit
    load_lanes();
    start_job(8'h11);
    run_idle(2);
    job_valid  = 1'b1;
    job_data   = 8'h3C;
    lane_found = 8'h01;
    tick();
    job_valid  = 1'b0;
    lane_found = '0;
    chk("abort_no_result", 256'(res_valid), 256'(1'b0));
    chk("abort_restart", 256'(lane_restart), 256'(1'b1));
    chk("abort_data", 256'(lane_data), 256'(8'h3C));
    chk("abort_hits", 256'(hit_count), 256'(exp_hits));
    tick();
    chk("abort_enable", 256'(lane_enable), 256'(1'b1));
    do_result(8'h01, 8'h00, 0);

    // Randomized jobs
    for (int it = 0; it < 25; it++) begin
      load_lanes();
      start_job(8'($urandom));
      run_idle($urandom_range(0, 5));
      mode = $urandom_range(0, 2);
      f = 8'($urandom);
      if (f == '0) f = 8'h40;
      e = 8'($urandom);
      if (&e) e[3] = 1'b0;
      case (mode)
        0: do_result(f, e, $urandom_range(0, 4));
        1: do_result(8'h00, 8'hFF, $urandom_range(0, 4));
        default: do_result(f, 8'hFF, $urandom_range(0, 4));
      endcase
    end

    // Test 5: reset while a result is pending
    load_lanes();
    start_job(8'($urandom));
    lane_found = 8'h02;
    tick();
    chk("t5_pending", 256'(res_valid), 256'(1'b1));
    rst = 1'b0;
    tick();
    rst = 1'b1;
    lane_found = '0;
    exp_hits = '0;
    chk("t5_res_valid", 256'(res_valid), 256'(1'b0));
    chk("t5_job_ready", 256'(job_ready), 256'(1'b1));
    chk("t5_hit_count", 256'(hit_count), 256'(0));
    chk("t5_enable", 256'(lane_enable), 256'(1'b0));
    chk("t5_busy", 256'(busy), 256'(1'b0));
    for (int i = 0; i < L; i++)
      chk($sformatf("lane_base%0d", i), 256'(lane_base[i*NW +: NW]), 256'(32'(i) * 32'h2000_0000));

    // Test 6: 4-lane, 16-bit build
    for (int i = 0; i < 4; i++)
      chk($sformatf("s_lane_base%0d", i), 256'(s_lane_base[i*16 +: 16]), 256'(16'(i) * 16'h4000));
    s_job_valid = 1'b1;
    s_job_data  = 8'h5A;
    tick();
    s_job_valid = 1'b0;
    tick();
    chk("s_enable", 256'(s_lane_enable), 256'(1'b1));
    s_lane_nonce = {16'h1111, 16'h2222, 16'hBEEF, 16'h4444};
    s_lane_found = 4'b0110;
    tick();
    chk("s_res_valid", 256'(s_res_valid), 256'(1'b1));
    chk("s_res_lane", 256'(s_res_lane), 256'(2'b01));
    chk("s_res_nonce", 256'(s_res_nonce), 256'(16'hBEEF));
    s_res_ready = 1'b1;
    tick();
    s_res_ready  = 1'b0;
    s_lane_found = '0;
    chk("s_valid_drop", 256'(s_res_valid), 256'(1'b0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hashing_nonce_dispatch.md
Name: hashing_nonce_dispatch

Overview:
Parametrised successor of the 8-way nonce search wrapper. Distributes one block-header job across LANES external nonce-search lanes, each covering an equal slice of the nonce space. Arbitrates lane hits into a registered result with a valid/ready handshake. Restarts all lanes on a new job and reports exhaustion when every lane runs out without a hit. Sits between the job/header source and the bank of nonce lanes.

Parameters:
LANES, 8, number of parallel lanes; power of 2, range 1..64
NONCE_W, 32, nonce width
HASH_W, 256, hash width
DATA_W, 8, job data width
LANE_W, $clog2(LANES) (min 1), lane index width (derived)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset
job_valid  in  1  new job offered
job_data  in  DATA_W  job payload
job_ready  out  1  job accepted when job_valid&&job_ready
lane_enable  out  1  lanes may iterate
lane_restart  out  1  one-cycle pulse: lanes reload base nonce and data
lane_data  out  DATA_W  registered current job data
lane_base  out  LANES*NONCE_W  slice i = i*(2^NONCE_W/LANES), constant
lane_found  in  LANES  lane hit, held until restart
lane_nonce  in  LANES*NONCE_W  per-lane golden nonce
lane_hash  in  LANES*HASH_W  per-lane hash
lane_exhausted  in  LANES  lane finished its slice, held until restart
res_valid  out  1  result held
res_ready  in  1  result consumed
res_nonce  out  NONCE_W  winning nonce
res_hash  out  HASH_W  winning hash
res_lane  out  LANE_W  winning lane index
res_exhausted  out  1  result is "no nonce found" (nonce/hash zero)
busy  out  1  state != IDLE
hit_count  out  16  saturating count of reported hits since reset

Behaviour:
- Reset (rst==0 at posedge): state IDLE; all outputs 0 except job_ready=1; lane_data=0; hit_count=0. Reset mid-search discards the search and any pending result.
- States: IDLE, START, RUN, REPORT.
- IDLE: job_ready=1. On accept: latch job_data to lane_data; go to START.
- START (1 cycle): lane_restart=1, lane_enable=0; go to RUN.
- RUN: lane_enable=1, job_ready=1.
  - Accepted job in RUN aborts: relatch data, go to START. Priority over a same-cycle hit; the hit is dropped.
  - Else if |lane_found: fixed priority, lowest index wins. Register winner's nonce/hash/index into res_*; res_exhausted=0; res_valid=1 next cycle; hit_count+1 (saturate 0xFFFF); go to REPORT. Latency: found sampled at edge N, res_valid high after edge N.
  - Else if &lane_exhausted: res_valid=1, res_exhausted=1, res_nonce=0, res_hash=0, res_lane=0; go to REPORT.
  - A hit and full exhaustion in the same cycle report the hit.
- REPORT: lane_enable=0 (lanes freeze), job_ready=0. res_* stable while res_valid&&!res_ready. On res_ready: res_valid=0 next cycle; go to IDLE. New jobs are back-pressured until then.
- Inputs with X/Z are not tolerated. Lanes are never re-enabled after a hit without lane_restart, so no duplicate report of the same hit.
- Lane slices: RANGE=2^NONCE_W/LANES, computed at NONCE_W+1 bits. Lane LANES-1 ends at 2^NONCE_W-1; wrap-around past the top is the lane's responsibility (it asserts lane_exhausted).
- LANES==1: res_lane is 1 bit and always 0.

Test Plan:
1. Reset, then job 0xA5; lane 3 raises found with nonce 0x6000_0010 on cycle 10 -> lane_restart pulse 1 cycle after accept; res_valid the cycle after found; res_nonce=0x6000_0010, res_lane=3, hit_count=1.
2. Lanes 2 and 5 found in the same cycle -> res_lane=2; res_* held stable with res_ready low for 20 cycles; deassert after res_ready; state IDLE.
3. All 8 lane_exhausted, no found -> res_exhausted=1, res_nonce=0; same-cycle variant with found[7]=1 -> res_lane=7, res_exhausted=0.
4. New job 0x3C accepted in RUN, same cycle as found[0] -> no result; lane_data=0x3C; second lane_restart pulse.
5. rst low for 1 cycle during REPORT -> res_valid=0, job_ready=1, hit_count=0, lane_enable=0; check lane_base slice i = i*0x2000_0000.
6. LANES=4, NONCE_W=16 build -> lane_base = 0x0000/0x4000/0x8000/0xC000; a hit on lane 1 gives res_lane=2'b01.
